axis_sum_responder: RTL and testbench
=====================================

Name: axis_sum_responder

Overview:
- Receiver/responder endpoint for number-generator traffic on the 2x2 axis_mesh.
- Accepts multi-beat AXI-Stream packets from a generator tile and sums each packet's beats.
- Returns one single-beat response packet carrying the sum to a fixed destination tile.
- Asserts DONE after NUM_PACKETS request/response exchanges; flags protocol errors.

Parameters:
TDATAW, 32, data width of both stream interfaces and of the sum
TDESTW, 4, destination field width
PKT_LEN, 4, expected beats per request packet (1..255)
NUM_PACKETS, 8, exchanges before DONE (1..65535)
RESP_DEST, 0, TDEST value placed on every response

Ports:
CLK  in  1  single clock, all logic rising-edge
RST_N  in  1  synchronous, active-high reset: 1 = reset; sampled on CLK
AXIS_S_TVALID  in  1  request beat valid
AXIS_S_TREADY  out  1  request beat accepted
AXIS_S_TDATA  in  TDATAW  request operand
AXIS_S_TLAST  in  1  last beat of request packet
AXIS_S_TDEST  in  TDESTW  ignored
AXIS_M_TVALID  out  1  response valid
AXIS_M_TREADY  in  1  response accepted by mesh
AXIS_M_TDATA  out  TDATAW  packet sum
AXIS_M_TLAST  out  1  always 1 while AXIS_M_TVALID=1
AXIS_M_TDEST  out  TDESTW  RESP_DEST
SUM_O  out  TDATAW  last completed sum (held)
PKT_CNT  out  16  completed exchanges
ERR  out  1  sticky protocol error
DONE  out  1  all exchanges complete

Behaviour:
- Reset (RST_N=1 at a clock edge): state RECV.
  - All outputs 0: TREADY, M_TVALID, M_TDATA, M_TLAST, SUM_O, PKT_CNT, ERR, DONE.
  - Internal accumulator and beat counter cleared.
  - AXIS_S_TREADY first goes 1 in the cycle after reset deasserts.
- Reset mid-packet or mid-response: the in-flight response is dropped immediately (M_TVALID=0 next cycle) and partial sums are discarded.
- States: RECV, RESP, FIN.
- RECV:
  - AXIS_S_TREADY=1, AXIS_M_TVALID=0.
  - Beat accepted when S_TVALID & S_TREADY: acc <= acc + TDATA, truncated mod 2^TDATAW (overflow wraps silently). beat_cnt (8 bit) increments, saturating at 255.
  - Accepted beat with TLAST=1:
    - resp_data <= acc + TDATA
    - ERR <= 1 if (beat_cnt+1) != PKT_LEN; saturation counts as a mismatch
    - next state RESP
  - Single-beat packets are legal and produce resp_data = TDATA.
- RESP:
  - AXIS_S_TREADY=0 (backpressure on the mesh).
  - AXIS_M_TVALID=1 from the cycle after the TLAST beat is accepted (1-cycle latency).
  - TDATA/TLAST/TDEST held stable until the handshake.
  - On M_TVALID & M_TREADY:
    - SUM_O <= resp_data; PKT_CNT++
    - acc and beat_cnt cleared
    - next state FIN if new PKT_CNT == NUM_PACKETS, else RECV
    - M_TVALID=0 next cycle
  - If M_TREADY is already high when TVALID rises, the handshake completes that cycle.
- FIN:
  - DONE=1 (held until reset); AXIS_M_TVALID=0.
  - AXIS_S_TREADY=1: excess beats are consumed and discarded so the mesh cannot deadlock. Each discarded beat sets ERR.
- PKT_CNT never exceeds NUM_PACKETS.
- AXIS_S_TDEST is never used.
- No combinational path from any input to any output: TREADY and TVALID are registered or decoded from state only.

Test Plan:
- Single packet, PKT_LEN=4, NUM_PACKETS=1: beats 1,2,3,4 with TLAST on 4 -> one cycle later M_TVALID=1, TDATA=10, TLAST=1, TDEST=0. Handshake -> SUM_O=10, PKT_CNT=1, DONE=1, ERR=0.
- Wrap: beats 0xFFFFFFFF,1,0,0 -> response TDATA=0x00000000, ERR=0.
- Backpressure: hold M_TREADY=0 for 5 cycles in RESP -> TVALID stays 1, TDATA stable, S_TREADY=0 throughout; also drive S_TVALID=1 -> no beat accepted. Release -> handshake in that cycle.
- Length error: 3-beat packet (TLAST on beat 3), PKT_LEN=4 -> response still sent with the 3-beat sum, ERR=1 and stays 1 through the next good packet.
- Full run NUM_PACKETS=8, random TVALID gaps, random M_TREADY -> 8 responses in order matching a scoreboard; DONE rises after the 8th handshake. A 9th packet is consumed, ERR=1, no response.
- Reset mid-packet after 2 beats -> all outputs 0. A fresh 4-beat packet 5,5,5,5 then yields TDATA=20, not polluted by the earlier beats.

Source files
------------

// File: rtl/axis_sum_responder_if.sv
// axis_sum_responder_if: AXI-Stream channel bundle with master/slave views
interface axis_sum_responder_if #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4
);
    logic              tvalid;
    logic              tready;
    logic [TDATAW-1:0] tdata;
    logic              tlast;
    logic [TDESTW-1:0] tdest;
    modport master (output tvalid, tdata, tlast, tdest, input tready);
    modport slave (input tvalid, tdata, tlast, tdest, output tready);
endinterface

// File: rtl/axis_sum_responder.sv
// axis_sum_responder: sums each request packet and answers with a single-beat sum packet
module axis_sum_responder #(
    parameter int TDATAW      = 32,
    parameter int TDESTW      = 4,
    parameter int PKT_LEN     = 4,
    parameter int NUM_PACKETS = 8,
    parameter int RESP_DEST   = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    axis_sum_responder_if.slave  axis_s,
    axis_sum_responder_if.master axis_m,
    output logic [TDATAW-1:0]    SUM_O,
    output logic [15:0]          PKT_CNT,
    output logic                 ERR,
    output logic                 DONE
);
    localparam logic [1:0] RECV = 2'd0, RESP = 2'd1, FIN = 2'd2;
    logic [1:0]        state_q, state_d;
    logic [TDATAW-1:0] acc_q, acc_d, resp_q, resp_d, sum_q, sum_d;
    logic [7:0]        beat_q, beat_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d, rdy_q, vld_q, s_fire, m_fire;
    assign s_fire = axis_s.tvalid & rdy_q;
    assign m_fire = axis_m.tready & vld_q;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        resp_d  = resp_q;
        sum_d   = sum_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_q == RECV && s_fire) begin
            acc_d  = acc_q + axis_s.tdata;
            beat_d = beat_q == 8'hFF ? beat_q : beat_q + 8'd1;
            if (axis_s.tlast) begin
                resp_d  = acc_d;
                err_d   = err_q | beat_q == 8'hFF | ({1'b0, beat_q} + 9'd1 != 9'(PKT_LEN));
                state_d = RESP;
            end
        end
        if (state_q == RESP && m_fire) begin
            sum_d   = resp_q;
            cnt_d   = cnt_q + 16'd1;
            acc_d   = '0;
            beat_d  = '0;
            state_d = cnt_d == 16'(NUM_PACKETS) ? FIN : RECV;
        end
        // beats arriving after the final exchange are drained so the mesh never stalls
        if (state_q == FIN && s_fire)
            err_d = 1'b1;
    end
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            state_q <= RECV;
            acc_q   <= '0;
            resp_q  <= '0;
            sum_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            resp_q  <= resp_d;
            sum_q   <= sum_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdy_q   <= state_d != RESP;
            vld_q   <= state_d == RESP;
        end
    end
    assign axis_s.tready = rdy_q;
    assign axis_m.tvalid = vld_q;
    assign axis_m.tdata  = resp_q;
    assign axis_m.tlast  = vld_q;
    assign axis_m.tdest  = vld_q ? TDESTW'(RESP_DEST) : '0;
    assign SUM_O         = sum_q;
    assign PKT_CNT       = cnt_q;
    assign ERR           = err_q;
    assign DONE          = state_q == FIN;
endmodule

// File: tb/tb_axis_sum_responder.sv
// tb_axis_sum_responder: directed checks of summing, wrap, backpressure, length errors, drain and reset
module tb_axis_sum_responder;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] SUM_O;
    logic [15:0] PKT_CNT;
    logic        ERR, DONE;
    int          errors = 0;
    int          checks = 0;
    axis_sum_responder_if #(.TDATAW(32), .TDESTW(4)) s_if ();
    axis_sum_responder_if #(.TDATAW(32), .TDESTW(4)) m_if ();
    axis_sum_responder dut (
        .CLK(CLK), .RST_N(RST_N), .axis_s(s_if.slave), .axis_m(m_if.master),
        .SUM_O(SUM_O), .PKT_CNT(PKT_CNT), .ERR(ERR), .DONE(DONE)
    );
    always #5 CLK = ~CLK;
    logic [31:0] pk [7][4] = '{
        '{32'd10, 32'd20, 32'd30, 32'd40},
        '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd6},
        '{32'd1, 32'd0, 32'd0, 32'd0},
        '{32'h1234, 32'h1111, 32'h2222, 32'h3333},
        '{32'hFFFF, 32'd1, 32'hFFFF, 32'd1},
        '{32'd100, 32'd200, 32'd300, 32'd400},
        '{32'hDEAD_0000, 32'hBEEF, 32'd0, 32'd1}
    };
    logic [31:0] pe [7] = '{32'd100, 32'd11, 32'd1, 32'h789A, 32'h2_0000, 32'd1000, 32'hDEAD_BEF0};
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic send_beat(input logic [31:0] d, input logic last, input int gap);
        int n;
        repeat (gap) tick;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = last;
        n = 0;
        while (s_if.tready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        if (n == 50) chk("s_ready_timeout", s_if.tready, 1);
        tick;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask
    task automatic recv(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (m_if.tvalid !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        chk({tag, "_vld"}, m_if.tvalid, 1);
        chk({tag, "_data"}, m_if.tdata, exp);
        chk({tag, "_last"}, m_if.tlast, 1);
        m_if.tready = 1'($urandom_range(0, 1));
        n = 0;
        while (!m_if.tready && n < 10) begin
            tick;
            chk({tag, "_hold"}, m_if.tdata, exp);
            m_if.tready = 1'($urandom_range(0, 1));
            n++;
        end
        m_if.tready = 1'b1;
        tick;
        m_if.tready = 1'b0;
        chk({tag, "_sum"}, SUM_O, exp);
        chk({tag, "_vld_drop"}, m_if.tvalid, 0);
    endtask
    initial begin
        RST_N = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tdest  = 4'hA;
        m_if.tready = 1'b0;
        repeat (3) tick;
        chk("rst_s_rdy", s_if.tready, 0);
        chk("rst_m_vld", m_if.tvalid, 0);
        chk("rst_m_data", m_if.tdata, 0);
        chk("rst_m_last", m_if.tlast, 0);
        chk("rst_sum", SUM_O, 0);
        chk("rst_cnt", PKT_CNT, 0);
        chk("rst_err", ERR, 0);
        chk("rst_done", DONE, 0);
        RST_N = 1'b0;
        chk("rdy_before_edge", s_if.tready, 0);
        tick;
        chk("rdy_after_edge", s_if.tready, 1);
        m_if.tready = 1'b1;
        send_beat(1, 0, 0);
        send_beat(2, 0, 0);
        send_beat(3, 0, 0);
        send_beat(4, 1, 0);
        chk("p1_vld", m_if.tvalid, 1);
        chk("p1_data", m_if.tdata, 10);
        chk("p1_last", m_if.tlast, 1);
        chk("p1_dest", m_if.tdest, 0);
        chk("p1_s_rdy", s_if.tready, 0);
        tick;
        m_if.tready = 1'b0;
        chk("p1_vld_drop", m_if.tvalid, 0);
        chk("p1_sum", SUM_O, 10);
        chk("p1_cnt", PKT_CNT, 1);
        chk("p1_err", ERR, 0);
        chk("p1_done", DONE, 0);
        chk("p1_s_rdy_back", s_if.tready, 1);
        send_beat(32'hFFFF_FFFF, 0, 0);
        send_beat(1, 0, 0);
        send_beat(0, 0, 0);
        send_beat(0, 1, 0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h55;
        s_if.tlast  = 1'b1;
        repeat (5) begin
            chk("bp_vld", m_if.tvalid, 1);
            chk("bp_data", m_if.tdata, 0);
            chk("bp_s_rdy", s_if.tready, 0);
            tick;
        end
        m_if.tready = 1'b1;
        tick;
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        chk("bp_vld_drop", m_if.tvalid, 0);
        chk("wrap_sum", SUM_O, 0);
        chk("wrap_cnt", PKT_CNT, 2);
        chk("wrap_err", ERR, 0);
        send_beat(7, 0, 0);
        send_beat(8, 0, 0);
        send_beat(9, 1, 0);
        recv("short", 24);
        chk("short_err", ERR, 1);
        chk("short_cnt", PKT_CNT, 3);
        send_beat(1, 0, 0);
        send_beat(1, 0, 1);
        send_beat(1, 0, 0);
        send_beat(1, 1, 2);
        recv("after_short", 4);
        chk("err_sticky", ERR, 1);
        chk("after_short_cnt", PKT_CNT, 4);
        send_beat(9, 0, 0);
        send_beat(9, 0, 0);
        RST_N = 1'b1;
        tick;
        chk("mid_rst_s_rdy", s_if.tready, 0);
        chk("mid_rst_vld", m_if.tvalid, 0);
        chk("mid_rst_sum", SUM_O, 0);
        chk("mid_rst_cnt", PKT_CNT, 0);
        chk("mid_rst_err", ERR, 0);
        chk("mid_rst_done", DONE, 0);
        RST_N = 1'b0;
        tick;
        for (int k = 0; k < 4; k++) send_beat(5, k == 3, 0);
        recv("fresh", 20);
        chk("fresh_cnt", PKT_CNT, 1);
        chk("fresh_err", ERR, 0);
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++) send_beat(pk[i][k], k == 3, $urandom_range(0, 2));
            chk("run_done_early", DONE, 0);
            recv($sformatf("run%0d", i), pe[i]);
        end
        chk("run_cnt", PKT_CNT, 8);
        chk("run_done", DONE, 1);
        chk("run_err", ERR, 0);
        chk("fin_s_rdy", s_if.tready, 1);
        for (int k = 0; k < 4; k++) send_beat(k + 1, k == 3, 0);
        chk("drain_err", ERR, 1);
        repeat (3) begin
            chk("drain_no_resp", m_if.tvalid, 0);
            tick;
        end
        chk("drain_cnt", PKT_CNT, 8);
        chk("drain_done", DONE, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
